// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM output stage.
package rgb_pwm_pkg;

  localparam int PWM_BITS    = 8;
  localparam int SCALE_STEPS = 9;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    PENDING
  } state_t;

  typedef struct packed {
    logic [PWM_BITS-1:0] red;
    logic [PWM_BITS-1:0] green;
    logic [PWM_BITS-1:0] blue;
  } rgb888_t;

  // Channel 0 = red, 1 = green, 2 = blue; lets per-channel logic be generated.
  function automatic logic [PWM_BITS-1:0] channel(input rgb888_t c, input int idx);
    logic [PWM_BITS-1:0] v;
    v = c.blue;
    if (idx == 0) v = c.red;
    else if (idx == 1) v = c.green;
    return v;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_timebase.sv
// Free-running PWM timebase: prescaler, 8-bit ramp, period_start pulse and
// the boundary strobe marking the clock edge on which the ramp wraps.
module pwm_timebase
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PWM_BITS-1:0] ramp,
  output logic                boundary,
  output logic                period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       presc_reg;
  logic [PWM_BITS-1:0] ramp_reg;
  logic                period_start_reg;
  logic                presc_wrap;

  assign presc_wrap = (presc_reg == PW'(PRESCALE - 1));
  assign boundary   = presc_wrap && (ramp_reg == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg        <= '0;
      ramp_reg         <= '0;
      period_start_reg <= 1'b0;
    end else begin
      presc_reg        <= presc_wrap ? '0 : presc_reg + PW'(1);
      if (presc_wrap)
        ramp_reg <= ramp_reg + PWM_BITS'(1);
      // The cycle after the wrap edge is the one with ramp == 0, prescale == 0.
      period_start_reg <= boundary;
    end
  end

  assign ramp         = ramp_reg;
  assign period_start = period_start_reg;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED output stage: brightness scaling via a 9-step shift-add multiplier,
// duty commit on PWM period boundaries, and registered PWM pin comparators.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic [7:0] brightness,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic       period_start
);

  state_t              state_reg;
  rgb888_t             colour_reg;
  rgb888_t             pending_reg;
  rgb888_t             active_reg;
  logic [8:0]          mult_reg;
  logic [3:0]          iter_reg;
  logic [15:0]         acc_reg  [3];
  logic [15:0]         acc_next [3];
  logic                pin_reg  [3];
  logic [PWM_BITS-1:0] ramp;
  logic                boundary;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .ramp         (ramp),
    .boundary     (boundary),
    .period_start (period_start)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    always_comb begin
      acc_next[gi] = acc_reg[gi];
      if (mult_reg[iter_reg])
        acc_next[gi] = acc_reg[gi] + ({8'b0, channel(colour_reg, gi)} << iter_reg);
    end

    // The ramp value of this cycle decides the pin level of the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        pin_reg[gi] <= 1'b0;
      else
        pin_reg[gi] <= (ramp < channel(active_reg, gi));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      colour_reg  <= '0;
      pending_reg <= '0;
      active_reg  <= '0;
      mult_reg    <= '0;
      iter_reg    <= '0;
      for (int c = 0; c < 3; c++)
        acc_reg[c] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            colour_reg <= {red, green, blue};
            mult_reg   <= {1'b0, brightness} + 9'd1;
            iter_reg   <= '0;
            for (int c = 0; c < 3; c++)
              acc_reg[c] <= '0;
            state_reg  <= SCALE;
          end
        end
        SCALE: begin
          for (int c = 0; c < 3; c++)
            acc_reg[c] <= acc_next[c];
          iter_reg <= iter_reg + 4'd1;
          if (iter_reg == 4'(SCALE_STEPS - 1)) begin
            pending_reg <= {acc_next[0][15:8], acc_next[1][15:8], acc_next[2][15:8]};
            state_reg   <= PENDING;
          end
        end
        PENDING: begin
          // Entering PENDING on the wrap edge itself waits for the next wrap.
          if (boundary) begin
            active_reg <= pending_reg;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign RGB_R    = pin_reg[0];
  assign RGB_G    = pin_reg[1];
  assign RGB_B    = pin_reg[2];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench: two driver instances (PRESCALE 1 and 4), randomized colours,
// expected duties and commit edges derived from plain arithmetic on cycle counts.
module tb_rgb_pwm_driver;

  typedef struct {
    int r;
    int g;
    int b;
    int commit;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [7:0] red        [2];
  logic [7:0] green      [2];
  logic [7:0] blue       [2];
  logic [7:0] brightness [2];
  logic [1:0] rgb_r;
  logic [1:0] rgb_g;
  logic [1:0] rgb_b;
  logic [1:0] period_start;

  int   checks;
  int   errors;
  int   cyc;
  int   free_edge [2];
  exp_t exp_q [2][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of clock edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    rgb_pwm_driver #(
      .PRESCALE ((gi == 0) ? 1 : 4)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid[gi]),
      .in_ready     (in_ready[gi]),
      .red          (red[gi]),
      .green        (green[gi]),
      .blue         (blue[gi]),
      .brightness   (brightness[gi]),
      .RGB_R        (rgb_r[gi]),
      .RGB_G        (rgb_g[gi]),
      .RGB_B        (rgb_b[gi]),
      .period_start (period_start[gi])
    );
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int per_of(input int idx);
    return (idx == 0) ? 256 : 1024;
  endfunction

  function automatic int scale(input int c, input int br);
    return (c * (br + 1)) / 256;
  endfunction

  // Caller is just after a negedge; returns just after the negedge following the transfer.
  task automatic send(input int idx, input int r, input int g, input int b, input int br);
    int   e_start;
    int   n0;
    int   budget;
    int   per;
    exp_t e;
    red[idx]        = 8'(r);
    green[idx]      = 8'(g);
    blue[idx]       = 8'(b);
    brightness[idx] = 8'(br);
    in_valid[idx]   = 1'b1;
    e_start = cyc + 1;
    budget  = 0;
    while (!in_ready[idx] && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready[idx]) begin
      check($sformatf("accept_timeout dut%0d", idx), budget, 0);
      in_valid[idx] = 1'b0;
      return;
    end
    @(negedge clk);
    n0 = cyc;
    in_valid[idx] = 1'b0;
    check($sformatf("accept_edge dut%0d", idx), n0,
          (e_start > free_edge[idx]) ? e_start : free_edge[idx]);
    per      = per_of(idx);
    e.r      = scale(r, br);
    e.g      = scale(g, br);
    e.b      = scale(b, br);
    e.commit = ((n0 + 10 + per - 1) / per) * per;
    exp_q[idx].push_back(e);
    free_edge[idx] = e.commit + 1;
    $display("send dut%0d rgb=(%0d,%0d,%0d) br=%0d edge=%0d -> duty=(%0d,%0d,%0d) commit=%0d",
             idx, r, g, b, br, n0, e.r, e.g, e.b, e.commit);
  endtask

  task automatic wait_idle(input int idx);
    int budget;
    budget = 0;
    while (!in_ready[idx] && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check($sformatf("idle_timeout dut%0d", idx), int'(in_ready[idx]), 1);
  endtask

  // Per-instance monitor: period_start timing, commit edges and per-period pin shape.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    localparam int P   = (gi == 0) ? 1 : 4;
    localparam int PER = 256 * P;
    int   cnt  [3];
    int   mism [3];
    int   cur  [3];
    logic prev_ready;

    always @(negedge clk) begin
      logic [2:0] act;
      exp_t       e;
      int         k;
      logic       m;
      if (!rst_n) begin
        exp_q[gi].delete();
        prev_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
          cnt[c]  = 0;
          mism[c] = 0;
          cur[c]  = 0;
        end
      end else begin
        k = cyc % PER;
        if (k == 0 || period_start[gi])
          check($sformatf("period_start dut%0d cyc%0d", gi, cyc),
                int'(period_start[gi]), int'(k == 0));
        if (k == 0) begin
          for (int c = 0; c < 3; c++) begin
            check($sformatf("high_count dut%0d ch%0d cyc%0d", gi, c, cyc), cnt[c], cur[c] * P);
            check($sformatf("pin_shape dut%0d ch%0d cyc%0d", gi, c, cyc), mism[c], 0);
            cnt[c]  = 0;
            mism[c] = 0;
          end
          if (!prev_ready && in_ready[gi]) begin
            if (exp_q[gi].size() == 0) begin
              check($sformatf("unexpected_commit dut%0d", gi), 1, 0);
            end else begin
              e = exp_q[gi].pop_front();
              check($sformatf("commit_edge dut%0d", gi), cyc, e.commit);
              cur[0] = e.r;
              cur[1] = e.g;
              cur[2] = e.b;
              $display("commit dut%0d cyc=%0d duty=(%0d,%0d,%0d)", gi, cyc, e.r, e.g, e.b);
            end
          end
        end else if (!prev_ready && in_ready[gi]) begin
          check($sformatf("commit_phase dut%0d cyc%0d", gi, cyc), k, 0);
        end
        act = {rgb_b[gi], rgb_g[gi], rgb_r[gi]};
        for (int c = 0; c < 3; c++) begin
          m = (k > 0) && (((k - 1) / P) < cur[c]);
          if (act[c]) cnt[c]++;
          if (act[c] !== m) mism[c]++;
        end
        prev_ready = in_ready[gi];
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    in_valid = '0;
    for (int i = 0; i < 2; i++) begin
      red[i] = '0; green[i] = '0; blue[i] = '0; brightness[i] = '0;
      free_edge[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_ready dut%0d", i), int'(in_ready[i]), 1);
      check($sformatf("reset_pins dut%0d", i), int'({rgb_r[i], rgb_g[i], rgb_b[i]}), 0);
      check($sformatf("reset_period_start dut%0d", i), int'(period_start[i]), 0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Full brightness, scaling, zero brightness.
    send(0, 128, 0, 255, 255);
    repeat (600) @(negedge clk);
    send(0, 200, 0, 0, 127);
    repeat (600) @(negedge clk);
    send(0, 200, 0, 0, 0);
    repeat (600) @(negedge clk);

    // Backpressure: second colour held while the first is pending.
    send(0, 10, 20, 30, 255);
    send(0, 0, 64, 0, 255);
    repeat (600) @(negedge clk);

    // PENDING entered on the wrap edge itself.
    wait_idle(0);
    while (((cyc + 10) % 256) != 0) @(negedge clk);
    send(0, 255, 255, 0, 255);
    repeat (700) @(negedge clk);

    // Randomized colours with random gaps (including back-to-back).
    repeat (8) begin
      send(0, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255));
      repeat ($urandom_range(0, 400)) @(negedge clk);
    end
    repeat (600) @(negedge clk);

    // Reset in the middle of SCALE while pins are active.
    send(0, 255, 255, 255, 255);
    repeat (600) @(negedge clk);
    send(0, 1, 2, 3, 4);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_pins dut0", int'({rgb_r[0], rgb_g[0], rgb_b[0]}), 0);
    check("midreset_ready dut0", int'(in_ready[0]), 1);
    free_edge[0] = 0;
    free_edge[1] = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (600) @(negedge clk);

    // Prescale 4 instance.
    send(1, 0, 0, 64, 255);
    repeat (1200) @(negedge clk);
    send(1, $urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (2500) @(negedge clk);

    check("queue_drained dut0", exp_q[0].size(), 0);
    check("queue_drained dut1", exp_q[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
